// File: rtl/reg_file_mp.sv
// Multi-read-port register file: one synchronous write port, NumRdPorts read ports
// with latency 0 or 1, and a hardware clear sweep after reset and on request.
module reg_file_mp #(
  parameter int unsigned           WordLength = 8,
  parameter int unsigned           AddrBits   = 3,
  parameter int unsigned           NumRdPorts = 2,
  parameter int unsigned           RdLatency  = 1,
  parameter logic [WordLength-1:0] InitValue  = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clr_i,
  input  logic                             wr_en_i,
  input  logic [AddrBits-1:0]              w_addr_i,
  input  logic [WordLength-1:0]            w_data_i,
  input  logic [NumRdPorts-1:0]            rd_en_i,
  input  logic [NumRdPorts*AddrBits-1:0]   r_addr_i,
  output logic [NumRdPorts*WordLength-1:0] r_data_o,
  output logic [NumRdPorts-1:0]            r_valid_o,
  output logic                             busy_o,
  output logic                             wr_drop_o
);

  localparam int unsigned Depth = 2 ** AddrBits;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [AddrBits-1:0]   r_cnt, w_cnt_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_wr_drop;
  logic                  w_mem_we;
  logic [AddrBits-1:0]   w_mem_addr;
  logic [WordLength-1:0] w_mem_data;
  logic [WordLength-1:0] r_mem [Depth];

  // Control state register; busy tracks the next state so it falls on the last sweep write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_SWEEP;
      r_cnt     <= '0;
      r_busy    <= 1'b1;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_wr_drop <= wr_en_i & r_busy;
    end
  end

  // Next-state logic and selection of the single array write for this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_mem_we    = 1'b0;
    w_mem_addr  = w_addr_i;
    w_mem_data  = w_data_i;
    case (r_state)
      ST_SWEEP: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_cnt;
        w_mem_data = InitValue;
        w_cnt_nxt  = AddrBits'(r_cnt + 1'b1);
        if (r_cnt == {AddrBits{1'b1}}) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      ST_IDLE: begin
        w_mem_we = wr_en_i;
        if (clr_i) begin
          w_state_nxt = ST_SWEEP;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_SWEEP;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b1;
      end
    endcase
  end

  // Storage array has no reset; only the sweep brings it to a known state.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  assign busy_o    = r_busy;
  assign wr_drop_o = r_wr_drop;

  for (genvar p = 0; p < int'(NumRdPorts); p++) begin : g_rd
    logic [AddrBits-1:0] w_raddr;
    assign w_raddr = r_addr_i[p*AddrBits +: AddrBits];

    if (RdLatency == 0) begin : g_async
      assign r_data_o[p*WordLength +: WordLength] = r_mem[w_raddr];
      assign r_valid_o[p]                         = rd_en_i[p] & ~r_busy;
    end else begin : g_sync
      logic [WordLength-1:0] r_rd_data;
      logic                  r_rd_valid;

      // Registered read; a same-cycle write to the read address is forwarded.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else if (rd_en_i[p] && !r_busy) begin
          r_rd_valid <= 1'b1;
          r_rd_data  <= (wr_en_i && (w_addr_i == w_raddr)) ? w_data_i : r_mem[w_raddr];
        end else begin
          r_rd_valid <= 1'b0;
        end
      end

      assign r_data_o[p*WordLength +: WordLength] = r_rd_data;
      assign r_valid_o[p]                         = r_rd_valid;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp: registered-read instance plus an
// asynchronous-read instance sharing the same stimulus.
module tb_reg_file_mp;

  localparam int unsigned W = 8;
  localparam int unsigned A = 3;
  localparam int unsigned P = 2;

  logic           clk = 1'b0;
  logic           rst_i, clr_i, wr_en_i;
  logic [A-1:0]   w_addr_i;
  logic [W-1:0]   w_data_i;
  logic [P-1:0]   rd_en_i;
  logic [P*A-1:0] r_addr_i;

  logic [P*W-1:0] r_data_o,  r_data0_o;
  logic [P-1:0]   r_valid_o, r_valid0_o;
  logic           busy_o,    busy0_o;
  logic           wr_drop_o, wr_drop0_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.WordLength(W), .AddrBits(A), .NumRdPorts(P), .RdLatency(1), .InitValue('0)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .wr_en_i(wr_en_i), .w_addr_i(w_addr_i),
    .w_data_i(w_data_i), .rd_en_i(rd_en_i), .r_addr_i(r_addr_i), .r_data_o(r_data_o),
    .r_valid_o(r_valid_o), .busy_o(busy_o), .wr_drop_o(wr_drop_o)
  );

  reg_file_mp #(.WordLength(W), .AddrBits(A), .NumRdPorts(P), .RdLatency(0), .InitValue('0)) u_dut_async (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .wr_en_i(wr_en_i), .w_addr_i(w_addr_i),
    .w_data_i(w_data_i), .rd_en_i(rd_en_i), .r_addr_i(r_addr_i), .r_data_o(r_data0_o),
    .r_valid_o(r_valid0_o), .busy_o(busy0_o), .wr_drop_o(wr_drop0_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d);
    wr_en_i  = 1'b1;
    w_addr_i = a;
    w_data_i = d;
    @(negedge clk);
    wr_en_i  = 1'b0;
  endtask

  task automatic rd2(input string tag, input logic [A-1:0] a0, input logic [A-1:0] a1,
                     input logic [W-1:0] e0, input logic [W-1:0] e1);
    rd_en_i  = 2'b11;
    r_addr_i = {a1, a0};
    @(negedge clk);
    rd_en_i  = 2'b00;
    check({tag, "_d0"}, 32'(r_data_o[0 +: W]), 32'(e0));
    check({tag, "_d1"}, 32'(r_data_o[W +: W]), 32'(e1));
    check({tag, "_v"},  32'(r_valid_o), 32'(2'b11));
  endtask

  // Counts consecutive sampled cycles with busy high, starting at the current negedge.
  task automatic count_busy(input string tag, input int exp);
    int n;
    n = 0;
    while (busy_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    int n;
    rst_i = 1'b1; clr_i = 1'b0; wr_en_i = 1'b0; w_addr_i = '0; w_data_i = '0;
    rd_en_i = '0; r_addr_i = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy",  32'(busy_o),    32'd1);
    check("rst_valid", 32'(r_valid_o), 32'd0);
    check("rst_data",  32'(r_data_o),  32'd0);
    check("rst_drop",  32'(wr_drop_o), 32'd0);

    rst_i = 1'b0;
    count_busy("init_busy_len", 8);
    for (int i = 0; i < 4; i++) rd2("init_rd", A'(i), A'(7 - i), 8'h00, 8'h00);
    @(negedge clk);
    check("rd_off_valid", 32'(r_valid_o), 32'd0);

    wr(3'd3, 8'hA5);
    rd2("wr_a5", 3'd3, 3'd3, 8'hA5, 8'hA5);

    // Write and read of entry 5 in the same cycle.
    wr_en_i = 1'b1; w_addr_i = 3'd5; w_data_i = 8'h3C;
    rd_en_i = 2'b01; r_addr_i = {3'd3, 3'd5};
    #1;
    check("async_old_data",  32'(r_data0_o[0 +: W]), 32'h00);
    check("async_valid",     32'(r_valid0_o), 32'(2'b01));
    @(negedge clk);
    wr_en_i = 1'b0; rd_en_i = 2'b00;
    check("bypass_data",     32'(r_data_o[0 +: W]), 32'h3C);
    check("bypass_valid",    32'(r_valid_o), 32'(2'b01));
    check("hold_port1",      32'(r_data_o[W +: W]), 32'hA5);
    check("async_new_data",  32'(r_data0_o[0 +: W]), 32'h3C);

    for (int i = 0; i < 8; i++) wr(A'(i), W'(8'h10 + i));
    rd2("fill_rd", 3'd4, 3'd7, 8'h14, 8'h17);

    // Clear request, dropped writes and ignored clear pulses during the sweep.
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    n = 0;
    for (int j = 0; j < 40; j++) begin
      if (!busy_o) break;
      n++;
      if (j == 0) begin wr_en_i = 1'b1; w_addr_i = 3'd2; w_data_i = 8'h77; clr_i = 1'b1; end
      if (j == 1) begin wr_en_i = 1'b0; clr_i = 1'b1; end
      if (j == 2) clr_i = 1'b0;
      if (j == 5) begin wr_en_i = 1'b1; w_addr_i = 3'd1; w_data_i = 8'h55; end
      if (j == 6) wr_en_i = 1'b0;
      @(negedge clk);
      if (j == 0) check("drop_pulse",  32'(wr_drop_o), 32'd1);
      if (j == 1) check("drop_clear",  32'(wr_drop_o), 32'd0);
      if (j == 5) check("drop_late",   32'(wr_drop_o), 32'd1);
    end
    check("clr_busy_len", 32'(n), 32'd8);
    for (int i = 0; i < 4; i++) rd2("clr_rd", A'(i), A'(7 - i), 8'h00, 8'h00);

    // Reset arriving while the sweep is at entry 4.
    for (int i = 0; i < 8; i++) wr(A'(i), W'(8'h20 + i));
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("mid_rst_busy",  32'(busy_o),    32'd1);
    check("mid_rst_valid", 32'(r_valid_o), 32'd0);
    count_busy("mid_rst_busy_len", 8);
    for (int i = 0; i < 4; i++) rd2("rst_rd", A'(i), A'(7 - i), 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
